// File: rtl/ex_if.sv
// ID/EX-to-EX/MEM bus of the execute stage: ID/EX contents, writeback forwarding,
// downstream stall, plus the EX/MEM register, fetch redirect and predictor update.
interface ex_if #(
   parameter int XLEN = 32
);
   logic            id_valid;
   logic [XLEN-1:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic [6:0]      id_opcode;
   logic [2:0]      id_funct3;
   logic [6:0]      id_funct7;
   logic [1:0]      id_alu_op;
   logic            id_alu_src, id_mtor, id_regwrite, id_memread, id_memwrite, id_branch;
   logic            id_pred_taken;
   logic [XLEN-1:0] id_pred_target;
   logic [1:0]      id_bp_state;
   logic            wb_fwd_en;
   logic [4:0]      wb_fwd_rd;
   logic [XLEN-1:0] wb_fwd_data;
   logic            mem_stall;

   logic            ex_ready;
   logic            exm_valid;
   logic [XLEN-1:0] exm_alu_result, exm_store_data;
   logic [4:0]      exm_rd;
   logic [2:0]      exm_funct3;
   logic            exm_mtor, exm_regwrite, exm_memread, exm_memwrite;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            bp_update_en;
   logic [XLEN-1:0] bp_update_pc, bp_target;
   logic            bp_taken;
   logic [1:0]      bp_state;

   modport master (
      output id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
             id_opcode, id_funct3, id_funct7, id_alu_op, id_alu_src, id_mtor, id_regwrite,
             id_memread, id_memwrite, id_branch, id_pred_taken, id_pred_target, id_bp_state,
             wb_fwd_en, wb_fwd_rd, wb_fwd_data, mem_stall,
      input  ex_ready, exm_valid, exm_alu_result, exm_store_data, exm_rd, exm_funct3,
             exm_mtor, exm_regwrite, exm_memread, exm_memwrite, redirect_valid, redirect_pc,
             bp_update_en, bp_update_pc, bp_target, bp_taken, bp_state
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
             id_opcode, id_funct3, id_funct7, id_alu_op, id_alu_src, id_mtor, id_regwrite,
             id_memread, id_memwrite, id_branch, id_pred_taken, id_pred_target, id_bp_state,
             wb_fwd_en, wb_fwd_rd, wb_fwd_data, mem_stall,
      output ex_ready, exm_valid, exm_alu_result, exm_store_data, exm_rd, exm_funct3,
             exm_mtor, exm_regwrite, exm_memread, exm_memwrite, redirect_valid, redirect_pc,
             bp_update_en, bp_update_pc, bp_target, bp_taken, bp_state
   );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution, load-use bubble, EX/MEM register.
// Define EX_MUL_EN to add the multi-cycle MUL/MULH/MULHSU/MULHU unit.
module ex_stage #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 4
) (
   input logic clk,
   input logic rst,
   ex_if.slave bus
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   if (MUL_CYCLES < 2) begin : g_bad_mul_cycles
      $error("MUL_CYCLES must be at least 2");
   end

   logic [XLEN-1:0] op_a, rs2_f, op_b, alu_res, target, pc4;
   logic            exm_fwd_ok, load_use, accept, is_jal, is_jalr, is_ctrl, taken, mispredict;
   logic            mul_busy, mul_start, mul_done;
   logic [XLEN-1:0] mul_res;
   logic [4:0]      mul_rd;
   logic [2:0]      mul_f3;

   // A load in EX/MEM has no data yet, so it is never a forwarding source.
   assign exm_fwd_ok = bus.exm_valid & bus.exm_regwrite & ~bus.exm_memread;
   assign load_use   = bus.id_valid & bus.exm_valid & bus.exm_memread & (bus.exm_rd != 5'd0) &
                       ((bus.exm_rd == bus.id_rs1) | (bus.exm_rd == bus.id_rs2));
   assign bus.ex_ready = ~bus.mem_stall & ~load_use & ~mul_busy;
   assign accept       = bus.id_valid & bus.ex_ready & ~bus.redirect_valid;

   always_comb begin
      op_a = bus.id_rs1_val;
      if (bus.id_rs1 != 5'd0) begin
         if (exm_fwd_ok && bus.exm_rd == bus.id_rs1)            op_a = bus.exm_alu_result;
         else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.id_rs1) op_a = bus.wb_fwd_data;
      end
      rs2_f = bus.id_rs2_val;
      if (bus.id_rs2 != 5'd0) begin
         if (exm_fwd_ok && bus.exm_rd == bus.id_rs2)            rs2_f = bus.exm_alu_result;
         else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.id_rs2) rs2_f = bus.wb_fwd_data;
      end
      op_b    = bus.id_alu_src ? bus.id_imm : rs2_f;
      pc4     = bus.id_pc + XLEN'(4);
      is_jal  = bus.id_opcode == OP_JAL;
      is_jalr = bus.id_opcode == OP_JALR;
      is_ctrl = bus.id_branch | is_jal | is_jalr;

      alu_res = op_a + op_b;
      if (is_jal || is_jalr)             alu_res = pc4;
      else if (bus.id_opcode == OP_LUI)   alu_res = bus.id_imm;
      else if (bus.id_opcode == OP_AUIPC) alu_res = bus.id_pc + bus.id_imm;
      else if (bus.id_alu_op == 2'b01)    alu_res = op_a - op_b;
      else if (bus.id_alu_op == 2'b10) begin
         case (bus.id_funct3)
            3'b000:  alu_res = (bus.id_opcode == OP_R && bus.id_funct7[5]) ? op_a - op_b : op_a + op_b;
            3'b001:  alu_res = op_a << op_b[4:0];
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = bus.id_funct7[5] ? XLEN'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
            3'b110:  alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
         endcase
      end

      taken = 1'b0;
      if (is_jal || is_jalr) taken = 1'b1;
      else if (bus.id_branch) begin
         case (bus.id_funct3)
            3'b000:  taken = op_a == rs2_f;
            3'b001:  taken = op_a != rs2_f;
            3'b100:  taken = $signed(op_a) <  $signed(rs2_f);
            3'b101:  taken = $signed(op_a) >= $signed(rs2_f);
            3'b110:  taken = op_a <  rs2_f;
            3'b111:  taken = op_a >= rs2_f;
            default: taken = 1'b0;
         endcase
      end
      target     = is_jalr ? ((op_a + bus.id_imm) & ~XLEN'(1)) : bus.id_pc + bus.id_imm;
      mispredict = (bus.id_pred_taken != taken) | (taken & (bus.id_pred_target != target));
   end

`ifdef EX_MUL_EN
   localparam int CW = $clog2(MUL_CYCLES) + 1;
   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;
   mul_state_t        m_state, m_next;
   logic [CW-1:0]     m_cnt;
   logic [XLEN-1:0]   m_a, m_b;
   logic [2*XLEN-1:0] m_ea, m_eb, m_prod;

   assign mul_start = accept & (bus.id_alu_op == 2'b10) & (bus.id_opcode == OP_R) &
                      (bus.id_funct7 == 7'b0000001);

   always_ff @(posedge clk or posedge rst)
      if (rst)                 m_state <= M_IDLE;
      else if (!bus.mem_stall) m_state <= m_next;

   always_comb begin
      m_next   = m_state;
      mul_busy = 1'b0;
      mul_done = 1'b0;
      case (m_state)
         M_BUSY: begin
            mul_busy = 1'b1;
            if (m_cnt == '0) begin
               mul_done = 1'b1;
               m_next   = M_DONE;
            end
         end
         default: m_next = mul_start ? M_BUSY : M_IDLE;
      endcase
   end

   // Operands are frozen at start so forwarding changes during BUSY cannot disturb them.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         m_cnt <= '0; m_a <= '0; m_b <= '0; mul_rd <= '0; mul_f3 <= '0;
      end else if (!bus.mem_stall) begin
         if (mul_start) begin
            m_cnt  <= CW'(MUL_CYCLES - 2);
            m_a    <= op_a;
            m_b    <= rs2_f;
            mul_rd <= bus.id_rd;
            mul_f3 <= bus.id_funct3;
         end else if (mul_busy && m_cnt != '0) begin
            m_cnt <= m_cnt - CW'(1);
         end
      end

   always_comb begin
      m_ea    = (mul_f3 == 3'b001 || mul_f3 == 3'b010) ? {{XLEN{m_a[XLEN-1]}}, m_a} : {{XLEN{1'b0}}, m_a};
      m_eb    = (mul_f3 == 3'b001) ? {{XLEN{m_b[XLEN-1]}}, m_b} : {{XLEN{1'b0}}, m_b};
      m_prod  = m_ea * m_eb;
      mul_res = (mul_f3 == 3'b000) ? m_prod[XLEN-1:0] : m_prod[2*XLEN-1:XLEN];
   end
`else
   assign mul_busy  = 1'b0;
   assign mul_start = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_res   = '0;
   assign mul_rd    = '0;
   assign mul_f3    = '0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.exm_valid <= 1'b0; bus.exm_alu_result <= '0; bus.exm_store_data <= '0;
         bus.exm_rd <= '0; bus.exm_funct3 <= '0; bus.exm_mtor <= 1'b0; bus.exm_regwrite <= 1'b0;
         bus.exm_memread <= 1'b0; bus.exm_memwrite <= 1'b0;
         bus.redirect_valid <= 1'b0; bus.redirect_pc <= '0;
         bus.bp_update_en <= 1'b0; bus.bp_update_pc <= '0; bus.bp_target <= '0;
         bus.bp_taken <= 1'b0; bus.bp_state <= '0;
      end else if (!bus.mem_stall) begin
         if (mul_done) begin
            bus.exm_valid      <= 1'b1;
            bus.exm_alu_result <= mul_res;
            bus.exm_store_data <= '0;
            bus.exm_rd         <= mul_rd;
            bus.exm_funct3     <= mul_f3;
            bus.exm_mtor       <= 1'b0;
            bus.exm_regwrite   <= 1'b1;
            bus.exm_memread    <= 1'b0;
            bus.exm_memwrite   <= 1'b0;
         end else begin
            bus.exm_valid      <= accept & ~mul_start;
            bus.exm_alu_result <= alu_res;
            bus.exm_store_data <= rs2_f;
            bus.exm_rd         <= bus.id_rd;
            bus.exm_funct3     <= bus.id_funct3;
            bus.exm_mtor       <= bus.id_mtor;
            bus.exm_regwrite   <= bus.id_regwrite;
            bus.exm_memread    <= bus.id_memread;
            bus.exm_memwrite   <= bus.id_memwrite;
         end
         bus.redirect_valid <= accept & is_ctrl & mispredict;
         bus.redirect_pc    <= taken ? target : pc4;
         bus.bp_update_en   <= accept & is_ctrl;
         bus.bp_update_pc   <= bus.id_pc;
         bus.bp_target      <= target;
         bus.bp_taken       <= taken;
         bus.bp_state       <= bus.id_bp_state;
      end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU/branch traffic
// checked against an arithmetic reference model.
module tb_ex_stage;
   localparam int XLEN = 32;
   localparam int MUL_CYCLES = 4;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_BR = 7'b1100011, OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ex_if #(.XLEN(XLEN)) bus ();
   ex_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_val = 0; bus.id_rs2_val = 0; bus.id_imm = 0;
      bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_opcode = 0; bus.id_funct3 = 0;
      bus.id_funct7 = 0; bus.id_alu_op = 0; bus.id_alu_src = 0; bus.id_mtor = 0;
      bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_branch = 0;
      bus.id_pred_taken = 0; bus.id_pred_target = 0; bus.id_bp_state = 0;
   endtask

   task automatic drive(input logic [6:0] opc, input logic [1:0] aop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] v1, v2, imm, input logic src, rw);
      idle();
      bus.id_valid = 1; bus.id_opcode = opc; bus.id_alu_op = aop; bus.id_funct3 = f3;
      bus.id_funct7 = f7; bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
      bus.id_rs1_val = v1; bus.id_rs2_val = v2; bus.id_imm = imm;
      bus.id_alu_src = src; bus.id_regwrite = rw;
   endtask

   function automatic logic [31:0] ref_alu(input bit is_r, input logic [2:0] f3, input bit alt,
                                           input logic [31:0] a, b);
      logic [63:0] ext;
      int sh;
      sh = int'(b[4:0]);
      case (f3)
         3'd0: return (is_r && alt) ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         3'd3: return {31'd0, a < b};
         3'd4: return a ^ b;
         3'd5: begin
            ext = alt ? {{32{a[31]}}, a} : {32'd0, a};
            ext = ext >> sh;
            return ext[31:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic test_reset();
      idle();
      bus.wb_fwd_en = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0; bus.mem_stall = 0;
      rst = 1;
      repeat (2) tick();
      n_chk++; if (bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exm_valid got %0h exp 0", bus.exm_valid); end
      n_chk++; if (bus.exm_alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %0h exp 0", bus.exm_alu_result); end
      n_chk++; if (bus.redirect_valid !== 1'b0 || bus.bp_update_en !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %0b%0b exp 00", bus.redirect_valid, bus.bp_update_en); end
      n_chk++; if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got %0h exp 1", bus.ex_ready); end
      rst = 0;
      tick();
   endtask

   task automatic test_addi_fwd();
      drive(OP_I, 2'b10, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 0, 0, 32'd5, 1, 1);
      tick();
      n_chk++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== 32'd5 || bus.exm_rd !== 5'd1) begin n_fail++; $display("FAIL addi got v%0b r%0h rd%0d exp v1 r5 rd1", bus.exm_valid, bus.exm_alu_result, bus.exm_rd); end
      // wb carries a stale x1; the EX/MEM copy must win
      drive(OP_R, 2'b10, 3'd0, 7'd0, 5'd2, 5'd1, 5'd1, 0, 0, 0, 0, 1);
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 1; bus.wb_fwd_data = 32'd99;
      tick();
      n_chk++; if (bus.exm_alu_result !== 32'd10) begin n_fail++; $display("FAIL fwd_exm got %0h exp a", bus.exm_alu_result); end
      drive(OP_R, 2'b10, 3'd0, 7'd0, 5'd5, 5'd1, 5'd1, 0, 0, 0, 0, 1);
      bus.wb_fwd_data = 32'd7;
      tick();
      n_chk++; if (bus.exm_alu_result !== 32'd14) begin n_fail++; $display("FAIL fwd_wb got %0h exp e", bus.exm_alu_result); end
      bus.wb_fwd_en = 0;
   endtask

   task automatic test_load_use();
      drive(OP_LD, 2'b00, 3'd2, 7'd0, 5'd3, 5'd0, 5'd0, 0, 0, 32'h10, 1, 1);
      bus.id_memread = 1; bus.id_mtor = 1;
      tick();
      n_chk++; if (bus.exm_valid !== 1'b1 || bus.exm_memread !== 1'b1) begin n_fail++; $display("FAIL lw_issue got v%0b m%0b exp 11", bus.exm_valid, bus.exm_memread); end
      drive(OP_R, 2'b10, 3'd0, 7'd0, 5'd4, 5'd3, 5'd3, 0, 0, 0, 0, 1);
      #1;
      n_chk++; if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_ready got %0h exp 0", bus.ex_ready); end
      tick();
      n_chk++; if (bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble got %0h exp 0", bus.exm_valid); end
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 32'h20;
      #1;
      n_chk++; if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_release got %0h exp 1", bus.ex_ready); end
      tick();
      n_chk++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== 32'h40) begin n_fail++; $display("FAIL loaduse_result got %0h exp 40", bus.exm_alu_result); end
      bus.wb_fwd_en = 0;
   endtask

   task automatic test_branch_drop();
      drive(OP_BR, 2'b01, 3'd0, 7'd0, 5'd0, 5'd6, 5'd7, 32'd9, 32'd9, 32'h40, 0, 0);
      bus.id_branch = 1; bus.id_pc = 32'h100; bus.id_bp_state = 2'b01;
      tick();
      n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h140) begin n_fail++; $display("FAIL beq_redirect got %0b %0h exp 1 140", bus.redirect_valid, bus.redirect_pc); end
      n_chk++; if (bus.bp_update_en !== 1'b1 || bus.bp_taken !== 1'b1 || bus.bp_update_pc !== 32'h100 || bus.bp_state !== 2'b01) begin n_fail++; $display("FAIL beq_bp got en%0b t%0b pc%0h s%0d exp 1 1 100 1", bus.bp_update_en, bus.bp_taken, bus.bp_update_pc, bus.bp_state); end
      drive(OP_I, 2'b10, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 0, 0, 32'd3, 1, 1);
      tick();
      n_chk++; if (bus.exm_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wrong_path_drop got v%0b r%0b exp 00", bus.exm_valid, bus.redirect_valid); end
   endtask

   task automatic test_jalr();
      drive(OP_JALR, 2'b00, 3'd0, 7'd0, 5'd1, 5'd9, 5'd0, 32'h203, 0, 32'd4, 1, 1);
      bus.id_pc = 32'h80; bus.id_pred_taken = 1; bus.id_pred_target = 32'h206;
      tick();
      n_chk++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_redirect got %0h exp 0", bus.redirect_valid); end
      n_chk++; if (bus.exm_alu_result !== 32'h84 || bus.bp_target !== 32'h206 || bus.bp_taken !== 1'b1) begin n_fail++; $display("FAIL jalr got r%0h t%0h exp 84 206", bus.exm_alu_result, bus.bp_target); end
   endtask

   task automatic test_stall();
      drive(OP_R, 2'b10, 3'd0, 7'h20, 5'd10, 5'd11, 5'd12, 32'd50, 32'd8, 0, 0, 1);
      bus.mem_stall = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++; if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got %0h exp 0", c, bus.ex_ready); end
         tick();
         n_chk++; if (bus.exm_alu_result !== 32'h84 || bus.exm_rd !== 5'd1 || bus.bp_update_en !== 1'b1) begin n_fail++; $display("FAIL stall_hold c%0d got %0h rd%0d bp%0b exp 84 1 1", c, bus.exm_alu_result, bus.exm_rd, bus.bp_update_en); end
      end
      bus.mem_stall = 0;
      tick();
      n_chk++; if (bus.exm_alu_result !== 32'd42 || bus.exm_rd !== 5'd10 || bus.bp_update_en !== 1'b0) begin n_fail++; $display("FAIL sub_after_stall got %0h rd%0d exp 2a rd10", bus.exm_alu_result, bus.exm_rd); end
   endtask

`ifdef EX_MUL_EN
   task automatic test_mul();
      logic [2:0]  f3s [3] = '{3'd0, 3'd1, 3'd3};
      logic [31:0] as  [3] = '{32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] bs  [3] = '{32'd7, 32'd5, 32'd2};
      logic [31:0] ex  [3] = '{32'd42, 32'hFFFF_FFFF, 32'd1};
      int lows;
      bit seen;
      for (int t = 0; t < 3; t++) begin
         idle(); tick();
         drive(OP_R, 2'b10, f3s[t], 7'd1, 5'd13, 5'd14, 5'd15, as[t], bs[t], 0, 0, 1);
         #1;
         n_chk++; if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL mul_start_ready t%0d got %0h exp 1", t, bus.ex_ready); end
         tick();
         idle();
         bus.wb_fwd_en = 1; bus.wb_fwd_rd = 14; bus.wb_fwd_data = 32'd100;
         lows = 0; seen = 0;
         for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.ex_ready === 1'b1) seen = 1;
            else begin lows++; tick(); end
         end
         n_chk++; if (!seen || lows != MUL_CYCLES - 1) begin n_fail++; $display("FAIL mul_busy_len t%0d got %0d exp %0d", t, lows, MUL_CYCLES - 1); end
         n_chk++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== ex[t] || bus.exm_rd !== 5'd13) begin n_fail++; $display("FAIL mul_result t%0d got %0h exp %0h", t, bus.exm_alu_result, ex[t]); end
         bus.wb_fwd_en = 0;
      end
   endtask
`else
   task automatic test_mul();
      drive(OP_R, 2'b10, 3'd0, 7'd1, 5'd13, 5'd14, 5'd15, 32'd6, 32'd7, 0, 0, 1);
      tick();
      idle();
      #1;
      n_chk++; if (bus.exm_alu_result !== 32'd13 || bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL funct7_1_as_add got %0h rdy%0b exp d 1", bus.exm_alu_result, bus.ex_ready); end
   endtask
`endif

   task automatic test_random_alu();
      bit pv = 0;
      logic [4:0] prd = 0;
      logic [31:0] pres = 0, a, b, ob, imm, v1, v2, pc, exp_r;
      logic [11:0] imm12;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [4:0] rd, rs1, rs2;
      int k;
      idle(); tick();
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 3);
         f3 = 3'($urandom); rd = 5'($urandom_range(0, 3));
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         v1 = $urandom; v2 = $urandom; pc = {$urandom_range(0, 4095), 2'b00};
         f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         if (k == 1) begin
            if (f3 == 3'd1) imm12 = {7'h00, 5'($urandom)};
            else if (f3 == 3'd5) imm12 = {f7, 5'($urandom)};
            else imm12 = 12'($urandom);
            f7 = imm12[11:5];
            imm = {{20{imm12[11]}}, imm12};
         end else imm = $urandom;
         bus.wb_fwd_en = 1'($urandom); bus.wb_fwd_rd = 5'($urandom_range(0, 3)); bus.wb_fwd_data = $urandom;
         a = v1; b = v2;
         if (rs1 != 0 && pv && prd == rs1) a = pres;
         else if (rs1 != 0 && bus.wb_fwd_en && bus.wb_fwd_rd == rs1) a = bus.wb_fwd_data;
         if (rs2 != 0 && pv && prd == rs2) b = pres;
         else if (rs2 != 0 && bus.wb_fwd_en && bus.wb_fwd_rd == rs2) b = bus.wb_fwd_data;
         ob = (k == 0) ? b : imm;
         case (k)
            0: begin exp_r = ref_alu(1, f3, f7[5], a, ob); drive(OP_R, 2'b10, f3, f7, rd, rs1, rs2, v1, v2, imm, 0, 1); end
            1: begin exp_r = ref_alu(0, f3, f7[5], a, ob); drive(OP_I, 2'b10, f3, f7, rd, rs1, rs2, v1, v2, imm, 1, 1); end
            2: begin exp_r = imm; drive(OP_LUI, 2'b00, f3, f7, rd, rs1, rs2, v1, v2, imm, 1, 1); end
            default: begin exp_r = pc + imm; drive(OP_AUIPC, 2'b00, f3, f7, rd, rs1, rs2, v1, v2, imm, 1, 1); end
         endcase
         bus.id_pc = pc;
         tick();
         n_chk++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== exp_r || bus.exm_rd !== rd) begin n_fail++; $display("FAIL rand_alu i%0d k%0d f3=%0d got %0h rd%0d exp %0h rd%0d", i, k, f3, bus.exm_alu_result, bus.exm_rd, exp_r, rd); end
         n_chk++; if (bus.exm_store_data !== b) begin n_fail++; $display("FAIL rand_store i%0d got %0h exp %0h", i, bus.exm_store_data, b); end
         pv = 1; prd = rd; pres = exp_r;
      end
      bus.wb_fwd_en = 0;
   endtask

   task automatic test_branch_random();
      logic [2:0]  f3s [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
      logic [31:0] v1, v2, imm, pc, tgt, epc;
      logic [2:0]  f3;
      logic [1:0]  st;
      bit tk, pt, mis;
      for (int i = 0; i < 32; i++) begin
         f3 = f3s[$urandom_range(0, 7)];
         v1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         v2 = ($urandom_range(0, 2) == 0) ? v1 : $urandom;
         imm = {{19{1'($urandom)}}, 12'($urandom), 1'b0};
         pc = {$urandom_range(0, 65535), 2'b00};
         st = 2'($urandom);
         case (f3)
            3'd0: tk = v1 == v2;
            3'd1: tk = v1 != v2;
            3'd4: tk = $signed(v1) < $signed(v2);
            3'd5: tk = !($signed(v1) < $signed(v2));
            3'd6: tk = v1 < v2;
            3'd7: tk = !(v1 < v2);
            default: tk = 0;
         endcase
         tgt = pc + imm;
         pt = 1'($urandom);
         drive(OP_BR, 2'b01, f3, 7'd0, 5'd0, 5'd10, 5'd11, v1, v2, imm, 0, 0);
         bus.id_branch = 1; bus.id_pc = pc; bus.id_pred_taken = pt; bus.id_bp_state = st;
         bus.id_pred_target = ($urandom_range(0, 1) != 0) ? tgt : tgt + 32'd8;
         mis = (pt != tk) || (tk && bus.id_pred_target != tgt);
         epc = tk ? tgt : pc + 32'd4;
         tick();
         n_chk++; if (bus.redirect_valid !== mis || bus.redirect_pc !== epc) begin n_fail++; $display("FAIL rand_br_redirect i%0d f3=%0d got %0b %0h exp %0b %0h", i, f3, bus.redirect_valid, bus.redirect_pc, mis, epc); end
         n_chk++; if (bus.bp_update_en !== 1'b1 || bus.bp_taken !== tk || bus.bp_target !== tgt || bus.bp_update_pc !== pc || bus.bp_state !== st) begin n_fail++; $display("FAIL rand_br_bp i%0d got t%0b %0h exp t%0b %0h", i, bus.bp_taken, bus.bp_target, tk, tgt); end
         idle(); tick();
         n_chk++; if (bus.redirect_valid !== 1'b0 || bus.bp_update_en !== 1'b0) begin n_fail++; $display("FAIL rand_br_pulse i%0d got %0b%0b exp 00", i, bus.redirect_valid, bus.bp_update_en); end
      end
   endtask

   task automatic test_reset_mid();
      drive(OP_R, 2'b10, 3'd0, 7'd1, 5'd13, 5'd14, 5'd15, 32'd3, 32'd4, 0, 0, 1);
      tick();
      idle();
      #2 rst = 1;
      #1;
      n_chk++; if (bus.exm_valid !== 1'b0 || bus.exm_alu_result !== 32'h0 || bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid got v%0b r%0h rdy%0b exp 0 0 1", bus.exm_valid, bus.exm_alu_result, bus.ex_ready); end
      tick();
      rst = 0;
      tick();
      n_chk++; if (bus.ex_ready !== 1'b1 || bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_after got rdy%0b v%0b exp 1 0", bus.ex_ready, bus.exm_valid); end
   endtask

   initial begin
      test_reset();
      test_addi_fwd();
      test_load_use();
      test_branch_drop();
      test_jalr();
      test_stall();
      test_mul();
      test_random_alu();
      test_branch_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
